sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Parametrised single-clock FIFO; next generation of the team's 8x16 FIFO buffer.
- Generalised in data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty flags, overflow/underflow pulses, and simultaneous read/write at full.
- Sits between a producer and a consumer in the same clock domain; used as the standard elastic buffer in datapaths.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (default 16 words).
- AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL (legal range 1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (legal range 0..DEPTH-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- write_en  in  1  push request.
- read_en  in  1  pop request.
- data_in  in  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  read data.
- data_valid  out  1  data_out holds a newly popped word this cycle (non-FWFT); head word present (FWFT).
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- almost_empty  out  1  count <= AE_LEVEL.
- almost_full  out  1  count >= AF_LEVEL.
- count  out  ADDR_WIDTH+1  words currently stored, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Pointers: wr_ptr and rd_ptr are binary, ADDR_WIDTH+1 bits; they wrap naturally modulo 2**(ADDR_WIDTH+1).
- RAM is addressed by ptr[ADDR_WIDTH-1:0].
- Flags and count:
  - count = wr_ptr - rd_ptr, modulo arithmetic, held as a register updated with the pointers.
  - empty, full, almost_empty and almost_full are all derived combinationally from the count register, so they are never stale.
- Accept rules, evaluated each rising clk edge:
  - rd_acc = read_en & ~empty.
  - wr_acc = write_en & (~full | rd_acc).
  - A write while full is accepted if a read is accepted in the same cycle: count stays DEPTH, and the pointers advance together.
  - A read while empty is rejected even if a write occurs in the same cycle; the write is accepted and count becomes 1.
- Count update: +1 on wr_acc only; -1 on rd_acc only; unchanged when both or neither occur.
- overflow = registered (write_en & ~wr_acc); underflow = registered (read_en & ~rd_acc). Each pulses for one cycle per rejected request.
- Memory write: mem[wr_ptr] <= data_in on wr_acc. The memory is not reset.
- Read path, default (non-FWFT):
  - On rd_acc, data_out <= mem[rd_ptr] and data_valid <= 1, i.e. one-cycle read latency.
  - Otherwise data_valid <= 0 and data_out holds its last value; it is not zeroed.
- Same-address read and write in one cycle (only possible at full): the read returns the old stored word.
- Reset, synchronous with rst high, takes priority over all other activity including mid-burst:
  - Pointers and count = 0; empty = 1; full = 0; almost_empty = 1; almost_full = 0 (given AF_LEVEL >= 1).
  - data_out = 0; data_valid = 0; overflow = 0; underflow = 0.
  - Requests presented during reset are discarded.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- When defined (first-word fall-through):
  - data_out continuously presents mem[rd_ptr] whenever ~empty.
  - data_valid = ~empty, combinational.
  - read_en acts as an acknowledge: it pops the presented word, and the next word appears in the following cycle.
  - The first word written into an empty FIFO appears on data_out one cycle after the write edge.
  - data_out is don't-care while empty.
- When undefined: the registered one-cycle-latency read path described in Behaviour applies.
- Accept rules, count, flags and overflow/underflow are identical in both modes.

Test Plan:
- Reset then idle → empty=1, almost_empty=1, full=0, count=0, data_out=0x00, data_valid=0.
- Write 0x01..0x10 (16 words, defaults) → count steps 1..16; almost_full rises when count=14; full=1 after the 16th write. A 17th write gives overflow one-cycle pulse, count stays 16.
- From full, read 16 words → data_out 0x01..0x10 in order, each one cycle after read_en with data_valid=1; empty=1 at the end. One extra read gives an underflow pulse.
- Full FIFO, write_en=read_en=1 with data 0xAA → both accepted, count stays 16, full stays 1. Later drain yields 0x02..0x10 then 0xAA.
- Empty FIFO, write_en=read_en=1 with 0x55 → read rejected (underflow pulse), count=1; next read returns 0x55.
- Write 40 words while reading continuously (pointer wraps twice) with FWFT_EN defined and undefined → output sequence matches input, no overflow or underflow; rst asserted mid-stream clears count to 0 on the next edge.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between sync_fifo_param and its producer/consumer.
// The master side drives requests and write data; the FIFO (slave) drives everything else.
interface sync_fifo_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  write_en;
    logic                  read_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output write_en, read_en, data_in,
        input  data_out, data_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  write_en, read_en, data_in,
        output data_out, data_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, programmable almost flags and
// overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for first-word fall-through reads.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input logic              clk,
    input logic              rst,
    sync_fifo_param_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam ptr_t DEPTH_CNT = ptr_t'(DEPTH);
    localparam ptr_t AF_CNT    = ptr_t'(AF_LEVEL);
    localparam ptr_t AE_CNT    = ptr_t'(AE_LEVEL);

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    ptr_t count;
    ptr_t wr_ptr_nxt;
    ptr_t rd_ptr_nxt;
    logic empty;
    logic full;
    logic rd_acc;
    logic wr_acc;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Flags come straight from the count register so they always match the stored state.
    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_empty = (count <= AE_CNT);
    assign bus.almost_full  = (count >= AF_CNT);
    assign bus.count        = count;

    // NOTE: every signal written here is assigned on every pass, so no latch is inferred.
    always_comb begin
        rd_acc     = bus.read_en & ~empty;
        wr_acc     = bus.write_en & (~full | rd_acc);
        wr_ptr_nxt = wr_ptr + ptr_t'(wr_acc);
        rd_ptr_nxt = rd_ptr + ptr_t'(rd_acc);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr_nxt;
            rd_ptr        <= rd_ptr_nxt;
            count         <= wr_ptr_nxt - rd_ptr_nxt;
            bus.overflow  <= bus.write_en & ~wr_acc;
            bus.underflow <= bus.read_en & ~rd_acc;
        end
    end

    // NOTE: the storage array has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.data_in;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.data_out   = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign bus.data_valid = ~empty;
`else
    // On a same-slot read and write at full, the read sees the word stored before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
        end else begin
            bus.data_valid <= rd_acc;
            if (rd_acc) begin
                bus.data_out <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: directed and random traffic against a queue model.
// Works with or without SYNC_FIFO_FWFT_EN defined.
module tb_sync_fifo_param;
    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int DEPTH      = 16;
    localparam int AF_LEVEL   = 14;
    localparam int AE_LEVEL   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sync_fifo_param_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

    sync_fifo_param #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .AF_LEVEL  (AF_LEVEL),
        .AE_LEVEL  (AE_LEVEL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO contents as a plain queue plus the expected registered outputs.
    logic [7:0] q[$];
    logic [7:0] exp_dout  = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ovf   = 1'b0;
    logic       exp_udf   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = q.size();
        check({tag, ":count"}, 32'(bus.count), 32'(n));
        check({tag, ":empty"}, 32'(bus.empty), 32'(n == 0));
        check({tag, ":full"}, 32'(bus.full), 32'(n == DEPTH));
        check({tag, ":almost_empty"}, 32'(bus.almost_empty), 32'(n <= AE_LEVEL));
        check({tag, ":almost_full"}, 32'(bus.almost_full), 32'(n >= AF_LEVEL));
        check({tag, ":overflow"}, 32'(bus.overflow), 32'(exp_ovf));
        check({tag, ":underflow"}, 32'(bus.underflow), 32'(exp_udf));
`ifdef SYNC_FIFO_FWFT_EN
        check({tag, ":data_valid"}, 32'(bus.data_valid), 32'(n != 0));
        if (n != 0) check({tag, ":data_out"}, 32'(bus.data_out), 32'(q[0]));
`else
        check({tag, ":data_valid"}, 32'(bus.data_valid), 32'(exp_valid));
        check({tag, ":data_out"}, 32'(bus.data_out), 32'(exp_dout));
`endif
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge.
    task automatic step(input string tag, input logic rs, input logic we, input logic re,
                        input logic [7:0] din);
        logic rd_ok;
        logic wr_ok;
        rst          = rs;
        bus.write_en = we;
        bus.read_en  = re;
        bus.data_in  = din;
        @(posedge clk);
        if (rs) begin
            q.delete();
            exp_dout  = 8'h00;
            exp_valid = 1'b0;
            exp_ovf   = 1'b0;
            exp_udf   = 1'b0;
        end else begin
            rd_ok     = re && (q.size() != 0);
            wr_ok     = we && ((q.size() < DEPTH) || rd_ok);
            exp_valid = rd_ok;
            if (rd_ok) exp_dout = q.pop_front();
            if (wr_ok) q.push_back(din);
            exp_ovf = we && !wr_ok;
            exp_udf = re && !rd_ok;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        int writes;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b0;
        bus.data_in  = 8'h00;

        // Reset with random requests presented; they must be discarded.
        @(negedge clk);
        step("reset", 1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
        step("reset", 1'b1, 1'b1, 1'b1, 8'hEE);
        step("idle", 1'b0, 1'b0, 1'b0, 8'h00);

        for (int i = 1; i <= DEPTH; i++) step("fill", 1'b0, 1'b1, 1'b0, 8'(i));
        step("overflow", 1'b0, 1'b1, 1'b0, 8'h77);
        step("after_overflow", 1'b0, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 1'b0, 1'b1, 8'h00);
        step("underflow", 1'b0, 1'b0, 1'b1, 8'h00);
        step("after_underflow", 1'b0, 1'b0, 1'b0, 8'h00);

        // Simultaneous write and read while full.
        for (int i = 1; i <= DEPTH; i++) step("refill", 1'b0, 1'b1, 1'b0, 8'(i));
        step("full_rw", 1'b0, 1'b1, 1'b1, 8'hAA);
        for (int i = 0; i < DEPTH; i++) step("drain_aa", 1'b0, 1'b0, 1'b1, 8'h00);

        // Simultaneous write and read while empty: read rejected, write kept.
        step("empty_rw", 1'b0, 1'b1, 1'b1, 8'h55);
        step("read_55", 1'b0, 1'b0, 1'b1, 8'h00);
        step("idle2", 1'b0, 1'b0, 1'b0, 8'h00);

        // Streaming 40 words with continuous reads; pointers wrap twice.
        step("stream", 1'b0, 1'b1, 1'b0, 8'($urandom));
        for (int i = 1; i < 40; i++) step("stream", 1'b0, 1'b1, 1'b1, 8'($urandom));
        step("stream_tail", 1'b0, 1'b0, 1'b1, 8'h00);

        // Random traffic, biased to pass through full and empty.
        writes = 0;
        for (int i = 0; i < 300; i++) begin
            logic we;
            logic re;
            we = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 70 : 30));
            re = ($urandom_range(0, 99) < ((i / 50) % 2 == 0 ? 30 : 70));
            if (we) writes++;
            step("random", 1'b0, we, re, 8'($urandom));
        end

        // Mid-stream reset with traffic still presented.
        for (int i = 0; i < 6; i++) step("pre_rst", 1'b0, 1'b1, 1'(i % 2), 8'($urandom));
        step("mid_rst", 1'b1, 1'b1, 1'b1, 8'($urandom));
        step("post_rst", 1'b0, 1'b0, 1'b0, 8'h00);
        step("post_rst_wr", 1'b0, 1'b1, 1'b0, 8'h3C);
        step("post_rst_rd", 1'b0, 1'b0, 1'b1, 8'h00);
        step("post_rst_idle", 1'b0, 1'b0, 1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
